// File: rtl/display_scan_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_controller_pkg
// Description : Shared constants, state type and helpers for the multiplexed
//               four-digit display scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
package display_scan_controller_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam int         IDX_W      = $clog2(NUM_DIGITS);
  localparam logic [3:0] ANODE_OFF  = 4'b1111;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  // Active-low one-cold anode pattern selecting a single digit slot
  function automatic logic [NUM_DIGITS-1:0] anode_for(input logic [IDX_W-1:0] idx);
    return ~(NUM_DIGITS'(1) << idx);
  endfunction

endpackage
`default_nettype wire

// File: rtl/display_scan_controller_refresh_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : refresh_prescaler
// Description : Free-running 0..REFRESH_DIV-1 counter with synchronous clear;
//               tick marks the last cycle of each digit slot.
// Revision    : 1.0 - initial release
// ============================================================================
module refresh_prescaler #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int                CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: held at zero while cleared, wraps after the terminal count
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/display_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_controller
// Description : Time-multiplexed scan of four display digits with a
//               double-buffered value set committed only at frame boundaries.
//               All outputs are registered and computed from next-cycle state
//               so the first SCAN cycle already presents slot 0.
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan_controller
  import display_scan_controller_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] digit_en,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [3:0] val0,
  input  logic [3:0] val1,
  input  logic [3:0] val2,
  input  logic [3:0] val3,
  output logic [3:0] anode,
  output logic [1:0] digit_sel,
  output logic [3:0] digit_value,
  output logic       frame_done
);

  scan_state_t state_q;
  scan_state_t state_d;

  logic [IDX_W-1:0]                idx_q;
  logic [IDX_W-1:0]                idx_d;
  logic [NUM_DIGITS-1:0][3:0]      disp_q;
  logic [NUM_DIGITS-1:0][3:0]      disp_d;
  logic [NUM_DIGITS-1:0][3:0]      pend_vals_q;
  logic [NUM_DIGITS-1:0][3:0]      pend_vals_d;
  logic                            pending_q;
  logic                            pending_d;

  logic [3:0]       anode_q;
  logic [3:0]       anode_d;
  logic [IDX_W-1:0] digit_sel_q;
  logic [IDX_W-1:0] digit_sel_d;
  logic [3:0]       digit_value_q;
  logic [3:0]       digit_value_d;
  logic             frame_done_q;
  logic             frame_done_d;
  logic             load_ready_q;
  logic             load_ready_d;

  logic clear;
  logic tick;
  logic wrap;
  logic commit;
  logic handshake;

  // The counter is held while idle and also on the cycle scanning stops, so
  // a restart always begins with a full-length slot 0.
  assign clear = (state_q == IDLE) || (state_d == IDLE);

  refresh_prescaler #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .tick  (tick)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: enable alone decides scanning vs. blanked
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable)  state_d = SCAN;
      SCAN:    if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Slot index, load buffer and frame-boundary commit
  always_comb begin
    wrap      = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));
    handshake = load_valid && load_ready_q;
    // Pending sets reach the display only between frames, or at once when idle
    commit    = pending_q && ((state_q == IDLE) || ((state_q == SCAN) && wrap));

    idx_d = idx_q;
    if (clear) begin
      idx_d = '0;
    end else if (tick) begin
      idx_d = idx_q + IDX_W'(1);
    end

    pend_vals_d = pend_vals_q;
    pending_d   = pending_q;
    disp_d      = disp_q;
    if (handshake) begin
      pend_vals_d = {val3, val2, val1, val0};
      pending_d   = 1'b1;
    end else if (commit) begin
      disp_d    = pend_vals_q;
      pending_d = 1'b0;
    end
  end

  // Output decode from next-cycle state so outputs line up with the new slot
  always_comb begin
    anode_d = ANODE_OFF;
    if ((state_d == SCAN) && digit_en[idx_d]) begin
      anode_d = anode_for(idx_d);
    end
    digit_sel_d   = idx_d;
    digit_value_d = disp_d[idx_d];
    frame_done_d  = wrap;
    load_ready_d  = ~pending_d;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q         <= '0;
      disp_q        <= '0;
      pend_vals_q   <= '0;
      pending_q     <= 1'b0;
      anode_q       <= ANODE_OFF;
      digit_sel_q   <= '0;
      digit_value_q <= '0;
      frame_done_q  <= 1'b0;
      load_ready_q  <= 1'b1;
    end else begin
      idx_q         <= idx_d;
      disp_q        <= disp_d;
      pend_vals_q   <= pend_vals_d;
      pending_q     <= pending_d;
      anode_q       <= anode_d;
      digit_sel_q   <= digit_sel_d;
      digit_value_q <= digit_value_d;
      frame_done_q  <= frame_done_d;
      load_ready_q  <= load_ready_d;
    end
  end

  assign anode       = anode_q;
  assign digit_sel   = digit_sel_q;
  assign digit_value = digit_value_q;
  assign frame_done  = frame_done_q;
  assign load_ready  = load_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scan_controller
// Description : Directed self-checking bench for display_scan_controller
//               with REFRESH_DIV=4 and hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scan_controller;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] digit_en;
  logic       load_valid;
  logic       load_ready;
  logic [3:0] val0, val1, val2, val3;
  logic [3:0] anode;
  logic [1:0] digit_sel;
  logic [3:0] digit_value;
  logic       frame_done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  display_scan_controller #(
    .REFRESH_DIV (DIV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .digit_en    (digit_en),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .val0        (val0),
    .val1        (val1),
    .val2        (val2),
    .val3        (val3),
    .anode       (anode),
    .digit_sel   (digit_sel),
    .digit_value (digit_value),
    .frame_done  (frame_done)
  );

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cycle(input string tag, input logic [3:0] a, input logic [1:0] sel,
                              input logic [3:0] val, input logic fd);
    step();
    check_eq({tag, "_anode"}, 8'(anode), 8'(a));
    check_eq({tag, "_sel"},   8'(digit_sel), 8'(sel));
    check_eq({tag, "_val"},   8'(digit_value), 8'(val));
    check_eq({tag, "_fd"},    8'(frame_done), 8'(fd));
  endtask

  task automatic expect_slot(input string tag, input logic [3:0] a, input logic [1:0] sel,
                             input logic [3:0] val, input logic fd_first);
    for (int i = 0; i < DIV; i++) begin
      expect_cycle(tag, a, sel, val, (i == 0) ? fd_first : 1'b0);
    end
  endtask

  task automatic set_vals(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
    val0 = a; val1 = b; val2 = c; val3 = d;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; digit_en = 4'b1111; load_valid = 1'b0;
    set_vals(4'h0, 4'h0, 4'h0, 4'h0);

    // Reset held two cycles with enable high
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("rst_anode", 8'(anode), 8'hF);
      check_eq("rst_ready", 8'(load_ready), 8'h1);
      check_eq("rst_fd",    8'(frame_done), 8'h0);
      check_eq("rst_sel",   8'(digit_sel), 8'h0);
      check_eq("rst_val",   8'(digit_value), 8'h0);
    end

    // Load 1,2,3,4 while idle; commit happens the following idle cycle
    reset = 1'b0; enable = 1'b0; load_valid = 1'b1;
    set_vals(4'h1, 4'h2, 4'h3, 4'h4);
    step();
    check_eq("idle_hs_ready", 8'(load_ready), 8'h0);
    check_eq("idle_anode",    8'(anode), 8'hF);
    load_valid = 1'b0;
    step();
    check_eq("idle_commit_ready", 8'(load_ready), 8'h1);
    check_eq("idle_anode2",       8'(anode), 8'hF);

    // Frame 1: full scan, no frame_done on entry
    enable = 1'b1;
    expect_slot("f1s0", 4'b1110, 2'd0, 4'h1, 1'b0);
    expect_slot("f1s1", 4'b1101, 2'd1, 4'h2, 1'b0);
    expect_slot("f1s2", 4'b1011, 2'd2, 4'h3, 1'b0);
    expect_slot("f1s3", 4'b0111, 2'd3, 4'h4, 1'b0);

    // Frame 2: frame_done on wrap, load during slot 1, blank slot 2
    expect_slot("f2s0", 4'b1110, 2'd0, 4'h1, 1'b1);
    expect_cycle("f2s1", 4'b1101, 2'd1, 4'h2, 1'b0);
    check_eq("f2s1_ready_pre", 8'(load_ready), 8'h1);
    load_valid = 1'b1;
    set_vals(4'h9, 4'h8, 4'h7, 4'h6);
    expect_cycle("f2s1", 4'b1101, 2'd1, 4'h2, 1'b0);
    check_eq("f2s1_ready_post", 8'(load_ready), 8'h0);
    // Offers while not ready must be ignored
    set_vals(4'hF, 4'hF, 4'hF, 4'hF);
    expect_cycle("f2s1", 4'b1101, 2'd1, 4'h2, 1'b0);
    expect_cycle("f2s1", 4'b1101, 2'd1, 4'h2, 1'b0);
    digit_en = 4'b1011;
    expect_slot("f2s2_blank", 4'b1111, 2'd2, 4'h3, 1'b0);
    check_eq("f2s2_ready", 8'(load_ready), 8'h0);
    digit_en = 4'b1111;
    expect_slot("f2s3", 4'b0111, 2'd3, 4'h4, 1'b0);
    check_eq("f2s3_ready", 8'(load_ready), 8'h0);
    load_valid = 1'b0;

    // Frame 3: new values committed at the wrap
    expect_cycle("f3s0", 4'b1110, 2'd0, 4'h9, 1'b1);
    check_eq("f3s0_ready", 8'(load_ready), 8'h1);
    for (int i = 1; i < DIV; i++) expect_cycle("f3s0", 4'b1110, 2'd0, 4'h9, 1'b0);
    expect_slot("f3s1", 4'b1101, 2'd1, 4'h8, 1'b0);
    expect_cycle("f3s2", 4'b1011, 2'd2, 4'h7, 1'b0);
    expect_cycle("f3s2", 4'b1011, 2'd2, 4'h7, 1'b0);

    // Enable drop mid-slot 2, then re-enable
    enable = 1'b0;
    step();
    check_eq("off_anode", 8'(anode), 8'hF);
    check_eq("off_fd",    8'(frame_done), 8'h0);
    step();
    check_eq("off_anode2", 8'(anode), 8'hF);
    enable = 1'b1;
    expect_slot("reen_s0", 4'b1110, 2'd0, 4'h9, 1'b0);
    expect_cycle("reen_s1", 4'b1101, 2'd1, 4'h8, 1'b0);

    // Reset while a set is pending discards it
    load_valid = 1'b1;
    set_vals(4'h5, 4'h5, 4'h5, 4'h5);
    step();
    check_eq("pend_ready", 8'(load_ready), 8'h0);
    load_valid = 1'b0; reset = 1'b1; enable = 1'b0;
    step();
    step();
    check_eq("rst2_ready", 8'(load_ready), 8'h1);
    check_eq("rst2_anode", 8'(anode), 8'hF);
    reset = 1'b0;
    step();
    check_eq("post_ready", 8'(load_ready), 8'h1);
    check_eq("post_val",   8'(digit_value), 8'h0);
    enable = 1'b1;
    expect_slot("post_s0", 4'b1110, 2'd0, 4'h0, 1'b0);
    expect_cycle("post_s1", 4'b1101, 2'd1, 4'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/display_scan_controller.md
DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 SHALL provide parameter REFRESH_DIV, default 100000, clk cycles per digit slot; legal values are 2 or more.
REQ-002 SHALL provide port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL provide port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL provide port enable, input, 1; 1 means scan, 0 means display off.
REQ-005 SHALL provide port digit_en, input, 4; per-slot enable, a 0 bit blanks that slot.
REQ-006 SHALL provide port load_valid, input, 1, a new value set is offered.
REQ-007 SHALL provide port load_ready, output, 1, the controller can accept a value set.
REQ-008 SHALL provide ports val0, val1, val2, val3, input, 4 each, the offered nibbles for slots 0..3.
REQ-009 SHALL provide port anode, output, 4, active-low digit select with at most one bit low.
REQ-010 SHALL provide port digit_sel, output, 2, the current slot index.
REQ-011 SHALL provide port digit_value, output, 4, the nibble for the current slot, feeding the downstream segment decoder.
REQ-012 SHALL provide port frame_done, output, 1, a one-cycle pulse at each frame wrap.

Function
REQ-013 SHALL implement states IDLE and SCAN; transitions are IDLE to SCAN when enable=1, and SCAN to IDLE when enable=0, both taking effect next cycle.
REQ-014 In IDLE SHALL hold the prescaler=0, the slot index=0 and anode=1111.
REQ-015 In SCAN the prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; tick is asserted in the cycle the count equals REFRESH_DIV-1.
REQ-016 On tick the slot index SHALL advance 0->1->2->3->0.
REQ-017 All outputs SHALL be registered; anode, digit_sel and digit_value reflect the new index in the cycle after tick.
REQ-018 In SCAN, anode SHALL equal ~(1<<idx) when digit_en[idx]=1, otherwise 1111; digit_value=disp[idx] regardless of blanking.
REQ-019 The first SCAN cycle after IDLE SHALL present idx 0, and slot 0 SHALL last REFRESH_DIV cycles.
REQ-020 frame_done SHALL be high for exactly the one cycle in which idx becomes 0 after idx 3; it is never asserted in IDLE.
REQ-021 A load handshake SHALL occur on load_valid & load_ready and capture val0..3 into pending registers, setting pending=1.
REQ-022 load_ready SHALL equal ~pending.
REQ-023 Commit (disp<=pending regs, pending<=0) SHALL occur on the 3->0 tick in SCAN, or on the first cycle with pending=1 in IDLE; the display is never updated mid-frame.
REQ-024 A handshake and a commit cannot occur in the same cycle, since load_ready=0 whenever pending=1; load_valid while load_ready=0 SHALL be ignored.
REQ-025 digit_en changes SHALL take effect at the next output register update without waiting for a frame boundary.
REQ-026 An enable drop with pending=1 SHALL cause the commit to occur in IDLE per REQ-023.

Reset
REQ-027 On reset the block SHALL enter IDLE with prescaler=0, idx=0, anode=1111, digit_sel=0, digit_value=0, frame_done=0, disp=0, pending regs=0, pending=0 and load_ready=1.
REQ-028 Reset mid-operation SHALL discard any pending value set and any partial frame; the first SCAN cycle after release follows REQ-019.

Structure
REQ-029 A shared package SHALL hold NUM_DIGITS=4, ANODE_OFF=4'b1111 and the state type {IDLE, SCAN}.
REQ-030 A single sub-module refresh_prescaler SHALL be instantiated, taking clk, reset, clear and REFRESH_DIV and producing tick.

Verification (REFRESH_DIV=4)
REQ-031 The bench SHALL verify: assert reset for 2 cycles with enable=1 -> anode=1111, load_ready=1, frame_done=0 throughout reset.
REQ-032 The bench SHALL verify: enable=1, digit_en=1111, load 1,2,3,4 while idle -> anode 1110/1101/1011/0111 each for 4 cycles with digit_value 1,2,3,4, and frame_done pulses once at the return to 1110.
REQ-033 The bench SHALL verify: digit_en=1011 -> slot 2 shows anode=1111 for 4 cycles while digit_sel=2 and digit_value=3.
REQ-034 The bench SHALL verify: load 9,8,7,6 during slot 1 -> load_ready=0 until the frame wrap, slots 2 and 3 still show 3,4, the next frame shows 9,8,7,6, then load_ready=1.
REQ-035 The bench SHALL verify: enable dropped during slot 2 -> anode=1111 next cycle; re-enable -> 1110 for a full 4 cycles.
REQ-036 The bench SHALL verify: reset while pending=1 -> after release, disp=0 and load_ready=1.
